mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency, pipelined memory between the instruction-fetch requester (I) and the load/store requester (D) of the RV32I core.
- Issues at most one memory access per grant and tracks the outstanding access with a latency counter.
- Returns read data or a write acknowledgement to the owning requester.
- Priority is fixed D-over-I, with an anti-starvation override for I.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from issue to mem_rdata valid; legal range >= 1.
- STARVE_MAX, 3, consecutive D grants allowed while I is waiting before I is forced; legal range >= 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low; asserted when 0.
- i_req  in  1  instruction read request; held with i_addr stable until i_gnt.
- i_addr  in  32  instruction fetch address.
- i_gnt  out  1  one-cycle pulse; I access issued this cycle.
- i_rvalid  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  32  fetched word.
- d_req  in  1  data request; held with d_we, d_addr, d_wdata and d_be stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables.
- d_gnt  out  1  one-cycle pulse; D access issued this cycle.
- d_rvalid  out  1  one-cycle pulse; load data valid, or store acknowledge.
- d_rdata  out  32  load data; 0 on store acknowledge.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  1 while an access is outstanding.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-low.
- Outputs under reset: while rst = 0, every output is 0; state returns to IDLE, lat_cnt = 0, starve_cnt = 0, owner is cleared.
- Reset mid-operation: an in-flight access is dropped. No rvalid is produced for it after rst returns to 1, even if the memory still returns data.
- FSM states:
  - IDLE: no access outstanding.
  - WAIT: one access outstanding; lat_cnt counts 1..MEM_LAT.
- Issue: the cycle a grant is given is the issue cycle, at most one grant per cycle. In that cycle:
  - mem_en = 1 and the matching gnt = 1.
  - mem_* are driven combinationally from the winner's inputs.
  - For I: mem_we = 0, mem_be = 4'hF, mem_wdata = 0.
  - When no access is issued, mem_en and mem_we are 0 and the other mem_* outputs are 0.
- Transitions:
  - IDLE -> WAIT on any grant; owner and owner_we are registered; lat_cnt = 1.
  - WAIT: lat_cnt increments each cycle.
  - When lat_cnt == MEM_LAT (response cycle): the owner's rvalid = 1 and rdata = mem_rdata (store: d_rdata = 0, mem_rdata ignored).
  - In the response cycle a new grant may issue (back-to-back). The FSM stays in WAIT with lat_cnt = 1 if a grant issues, otherwise goes to IDLE.
  - Sustained throughput is one access per MEM_LAT cycles. With MEM_LAT = 1, one access per cycle.
- No grant in WAIT before the response cycle. Requests simply stay held.
- busy = 1 in WAIT, including the response cycle.
- Arbitration when a grant is possible:
  - Only one request active: it wins.
  - Both active: D wins, unless starve_cnt == STARVE_MAX, in which case I wins.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each D grant given while i_req = 1.
  - Clears on an I grant, and in any cycle where i_req = 0.
- Addresses and byte enables pass through unmodified; no alignment checks.
- A requester that drops req before its gnt is simply not served. This is legal; no error is raised.

Test Plan:
- Reset: drive rst = 0 for 2 cycles with i_req = d_req = 1 -> all outputs 0; first i_gnt/d_gnt/mem_en appear only in the cycle rst = 1.
- Single I read, MEM_LAT = 2: i_req = 1, i_addr = 0x0000_0010, memory returns 0x0051_0093 -> i_gnt at t, mem_addr = 0x10, mem_be = 4'hF; i_rvalid at t+2 with i_rdata = 0x0051_0093; busy high t..t+2.
- D store then load, MEM_LAT = 2:
  - Store: d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF, d_be = 4'b0011 -> mem_we = 1 with those values; d_rvalid at t+2 with d_rdata = 0.
  - Load: grant at t+2 -> d_rdata = memory value at t+4.
- Contention and anti-starvation, STARVE_MAX = 3, MEM_LAT = 1, both requests held continuously -> grant order D, D, D, I, D, D, D, I. Never more than 3 consecutive D grants.
- Reset mid-op: issue a D load at t, drive rst = 0 at t+1 for one cycle, MEM_LAT = 2 -> no d_rvalid at t+2 or later for that load; busy = 0 after reset.
- Request withdrawal: in WAIT, i_req rises then falls before the response cycle -> no i_gnt; the next pending D request is granted in the response cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                           |
// | Purpose  : Shares one fixed-latency pipelined memory port between the |
// |            instruction-fetch (I) and load/store (D) requesters.       |
// |            D has priority; I is forced after STARVE_MAX D grants.     |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int LW = (MEM_LAT    < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] C_LAT    = LW'(MEM_LAT);
  localparam logic [SW-1:0] C_STARVE = SW'(STARVE_MAX);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          owner_d_q, owner_d_d;   // 1 = outstanding access belongs to D
  logic          owner_we_q, owner_we_d; // 1 = outstanding access is a store

  logic w_resp;
  logic w_can_gnt;
  logic w_pick_d;
  logic w_pick_i;
  logic w_gnt_d;
  logic w_gnt_i;

  // Arbitration and grant generation; all outputs are forced low in reset.
  always_comb begin
    w_resp    = (state_q == ST_WAIT) && (lat_cnt_q == C_LAT);
    w_can_gnt = rst && ((state_q == ST_IDLE) || w_resp);
    w_pick_d  = d_req && (!i_req || (starve_q != C_STARVE));
    w_pick_i  = i_req && !w_pick_d;
    w_gnt_d   = w_can_gnt && w_pick_d;
    w_gnt_i   = w_can_gnt && w_pick_i;
  end

  // Memory-side and requester-side outputs.
  always_comb begin
    i_gnt     = w_gnt_i;
    d_gnt     = w_gnt_d;
    mem_en    = w_gnt_i || w_gnt_d;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    if (w_gnt_d) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (w_gnt_i) begin
      mem_addr  = i_addr;
      mem_be    = 4'hF;
    end
    i_rvalid = rst && w_resp && !owner_d_q;
    d_rvalid = rst && w_resp && owner_d_q;
    i_rdata  = i_rvalid ? mem_rdata : 32'h0;
    d_rdata  = (d_rvalid && !owner_we_q) ? mem_rdata : 32'h0;
    // An access counts as outstanding from its issue cycle through its response.
    busy     = rst && ((state_q == ST_WAIT) || mem_en);
  end

  // Next-state logic for the access tracker and starvation counter.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    owner_d_d  = owner_d_q;
    owner_we_d = owner_we_q;
    starve_d   = starve_q;

    if (w_gnt_i || w_gnt_d) begin
      state_d    = ST_WAIT;
      lat_cnt_d  = LW'(1);
      owner_d_d  = w_gnt_d;
      owner_we_d = w_gnt_d && d_we;
    end else if (state_q == ST_WAIT) begin
      if (w_resp) begin
        state_d   = ST_IDLE;
        lat_cnt_d = '0;
      end else begin
        lat_cnt_d = lat_cnt_q + LW'(1);
      end
    end

    if (!i_req || w_gnt_i) begin
      starve_d = '0;
    end else if (w_gnt_d && (starve_q != C_STARVE)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // State registers; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      lat_cnt_q  <= '0;
      starve_q   <= '0;
      owner_d_q  <= 1'b0;
      owner_we_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      starve_q   <= starve_d;
      owner_d_q  <= owner_d_d;
      owner_we_q <= owner_we_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | Module   : tb_mem_port_arbiter                                        |
// | Purpose  : Directed self-checking bench; one instance with MEM_LAT=2  |
// |            and one with MEM_LAT=1 share the same stimulus.            |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] mem_rdata;

  logic        i_gnt2, i_rvalid2, d_gnt2, d_rvalid2, mem_en2, mem_we2, busy2;
  logic [31:0] i_rdata2, d_rdata2, mem_addr2, mem_wdata2;
  logic [3:0]  mem_be2;

  logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, busy1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic [3:0]  mem_be1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) u_lat2 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt2), .i_rvalid(i_rvalid2), .i_rdata(i_rdata2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_be(mem_be2), .mem_rdata(mem_rdata), .busy(busy2)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) u_lat1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_be(mem_be1), .mem_rdata(mem_rdata), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then applied.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic chk_all_zero2(input string tag);
    chk({tag, "_i_gnt"},    {31'd0, i_gnt2},    32'd0);
    chk({tag, "_d_gnt"},    {31'd0, d_gnt2},    32'd0);
    chk({tag, "_mem_en"},   {31'd0, mem_en2},   32'd0);
    chk({tag, "_mem_we"},   {31'd0, mem_we2},   32'd0);
    chk({tag, "_mem_addr"}, mem_addr2,          32'd0);
    chk({tag, "_mem_be"},   {28'd0, mem_be2},   32'd0);
    chk({tag, "_busy"},     {31'd0, busy2},     32'd0);
    chk({tag, "_rvalid"},   {30'd0, i_rvalid2, d_rvalid2}, 32'd0);
    chk({tag, "_lat1_en"},  {31'd0, mem_en1},   32'd0);
  endtask

  initial begin
    logic [7:0] exp_d_seq;
    rst = 1'b0; i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h80; d_wdata = 32'h0; d_be = 4'hF; mem_rdata = 32'h0;

    // Reset held two cycles with both requests pending.
    tick(); settle(); chk_all_zero2("rst_c1");
    tick(); settle(); chk_all_zero2("rst_c2");

    // First grant appears in the first cycle out of reset; D wins.
    tick(); rst = 1'b1; settle();
    chk("rst_exit_d_gnt",  {31'd0, d_gnt2},  32'd1);
    chk("rst_exit_i_gnt",  {31'd0, i_gnt2},  32'd0);
    chk("rst_exit_mem_en", {31'd0, mem_en2}, 32'd1);
    tick(); i_req = 1'b0; d_req = 1'b0;
    tick(); tick(); settle();
    chk("drain_busy", {31'd0, busy2}, 32'd0);

    // Single I read.
    i_req = 1'b1; i_addr = 32'h0000_0010; settle();
    chk("iread_gnt",   {31'd0, i_gnt2}, 32'd1);
    chk("iread_addr",  mem_addr2,       32'h10);
    chk("iread_be",    {28'd0, mem_be2}, 32'hF);
    chk("iread_we",    {31'd0, mem_we2}, 32'd0);
    chk("iread_busy0", {31'd0, busy2},  32'd1);
    tick(); i_req = 1'b0; settle();
    chk("iread_busy1", {31'd0, busy2},    32'd1);
    chk("iread_rv1",   {31'd0, i_rvalid2}, 32'd0);
    tick(); mem_rdata = 32'h0051_0093; settle();
    chk("iread_rv2",   {31'd0, i_rvalid2}, 32'd1);
    chk("iread_rdata", i_rdata2,           32'h0051_0093);
    chk("iread_drv2",  {31'd0, d_rvalid2}, 32'd0);
    chk("iread_busy2", {31'd0, busy2},     32'd1);
    tick(); settle();
    chk("iread_busy3", {31'd0, busy2},     32'd0);
    chk("iread_rv3",   {31'd0, i_rvalid2}, 32'd0);

    // D store.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    settle();
    chk("st_gnt",   {31'd0, d_gnt2},  32'd1);
    chk("st_we",    {31'd0, mem_we2}, 32'd1);
    chk("st_addr",  mem_addr2,        32'h100);
    chk("st_wdata", mem_wdata2,       32'hDEAD_BEEF);
    chk("st_be",    {28'd0, mem_be2}, 32'h3);
    tick(); d_req = 1'b0;
    // Store ack and back-to-back load grant in the same cycle.
    tick(); mem_rdata = 32'h1234_5678;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104; d_wdata = 32'h0; d_be = 4'hF; settle();
    chk("st_ack",    {31'd0, d_rvalid2}, 32'd1);
    chk("st_rdata",  d_rdata2,           32'h0);
    chk("ld_gnt",    {31'd0, d_gnt2},    32'd1);
    chk("ld_we",     {31'd0, mem_we2},   32'd0);
    chk("ld_addr",   mem_addr2,          32'h104);
    tick(); d_req = 1'b0; settle();
    chk("ld_rv_early", {31'd0, d_rvalid2}, 32'd0);
    tick(); mem_rdata = 32'hCAFE_F00D; settle();
    chk("ld_rv",    {31'd0, d_rvalid2}, 32'd1);
    chk("ld_rdata", d_rdata2,           32'hCAFE_F00D);
    tick();

    // Reset in the middle of an outstanding load.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; settle();
    chk("mid_gnt", {31'd0, d_gnt2}, 32'd1);
    tick(); d_req = 1'b0; rst = 1'b0; settle();
    chk("mid_rst_busy", {31'd0, busy2},     32'd0);
    chk("mid_rst_rv",   {31'd0, d_rvalid2}, 32'd0);
    tick(); rst = 1'b1; mem_rdata = 32'hBAD0_BAD0; settle();
    chk("mid_rv_t2",   {31'd0, d_rvalid2}, 32'd0);
    chk("mid_busy_t2", {31'd0, busy2},     32'd0);
    tick(); settle();
    chk("mid_rv_t3",   {31'd0, d_rvalid2}, 32'd0);

    // I request withdrawn while waiting; pending D served in the response cycle.
    d_req = 1'b1; d_addr = 32'h300; settle();
    chk("wd_gnt0", {31'd0, d_gnt2}, 32'd1);
    tick(); d_addr = 32'h304; i_req = 1'b1; settle();
    chk("wd_gnt1", {30'd0, i_gnt2, d_gnt2}, 32'd0);
    tick(); i_req = 1'b0; mem_rdata = 32'h1111_1111; settle();
    chk("wd_rv",    {31'd0, d_rvalid2}, 32'd1);
    chk("wd_rdata", d_rdata2,           32'h1111_1111);
    chk("wd_d_gnt", {31'd0, d_gnt2},    32'd1);
    chk("wd_i_gnt", {31'd0, i_gnt2},    32'd0);
    chk("wd_addr",  mem_addr2,          32'h304);
    tick(); d_req = 1'b0;
    tick(); tick();

    // Contention with MEM_LAT=1: D,D,D,I repeating (bit k = 1 means D).
    exp_d_seq = 8'b0111_0111;
    i_req = 1'b1; i_addr = 32'h500; d_req = 1'b1; d_addr = 32'h600;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk($sformatf("starve_d%0d", k), {31'd0, d_gnt1}, {31'd0, exp_d_seq[k]});
      chk($sformatf("starve_i%0d", k), {31'd0, i_gnt1}, {31'd0, ~exp_d_seq[k]});
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
